// File: rtl/mips32_mem_pkg.sv
// Shared definitions for the MIPS32 data-memory responder and its storage array.
package mips32_mem_pkg;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = WORD_BYTES;
    localparam int WAIT_CNT_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } dmem_state_e;

    function automatic logic is_word_aligned(input logic [1:0] addr_lo);
        return addr_lo == 2'b00;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Word-organised RAM: byte-enabled synchronous write, combinational read.
module dmem_array
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [IDX_W-1:0]  idx,
    input  logic [BE_W-1:0]   be,
    input  logic [31:0]       wdata,
    output logic [31:0]       rdata
);

    // No reset: contents survive a responder reset.
    logic [31:0] mem [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < BE_W; b++) begin
                if (be[b]) begin
                    mem[idx][8*b +: 8] <= wdata[8*b +: 8];
                end
            end
        end
    end

    assign rdata = mem[idx];

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: one request at a time, fixed wait, then access and
// a response held until taken.
module dmem_responder
    import mips32_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    input  logic [BE_W-1:0]   req_be,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_rdata,
    output logic              rsp_err,
    output logic [1:0]        dbg_state
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);

    // Handshake: a transfer happens on a rising edge where valid && ready.
    // req_ready is high only in IDLE, rsp_valid only in RESP, so the two are
    // never high together; the response holds steady until rsp_ready.

    dmem_state_e            state;
    logic [WAIT_CNT_W-1:0]  cnt;
    logic                   lat_write;
    logic [31:0]            lat_addr;
    logic [31:0]            lat_wdata;
    logic [BE_W-1:0]        lat_be;
    logic [31:0]            rdata_q;
    logic                   err_q;

    logic                   access;
    logic                   addr_err;
    logic                   mem_we;
    logic [31:0]            mem_rdata;

    assign access   = (state == ST_WAIT) && (cnt == '0);
    assign addr_err = !is_word_aligned(lat_addr[1:0]) ||
                      (lat_addr[31:2] >= 30'(DEPTH_WORDS));
    // Erroring stores never reach the array.
    assign mem_we   = access && lat_write && !addr_err;

    dmem_array #(
        .DEPTH_WORDS (DEPTH_WORDS)
    ) u_array (
        .clk   (clk),
        .we    (mem_we),
        .idx   (lat_addr[IDX_W+1:2]),
        .be    (lat_be),
        .wdata (lat_wdata),
        .rdata (mem_rdata)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            lat_write <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            lat_be    <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (req_valid) begin
                        lat_write <= req_write;
                        lat_addr  <= req_addr;
                        lat_wdata <= req_wdata;
                        lat_be    <= req_be;
                        cnt       <= WAIT_CNT_W'(WAIT_CYCLES);
                        state     <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt != '0) begin
                        cnt <= cnt - 4'd1;
                    end else begin
                        err_q   <= addr_err;
                        rdata_q <= (addr_err || lat_write) ? 32'h0 : mem_rdata;
                        state   <= ST_RESP;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign req_ready = (state == ST_IDLE);
    assign rsp_valid = (state == ST_RESP);
    assign rsp_rdata = rdata_q;
    assign rsp_err   = err_q;
    assign dbg_state = state;

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder with a reference memory model and
// an expected-response queue.
module tb_dmem_responder;
    import mips32_mem_pkg::*;

    localparam int DEPTH = 256;
    localparam int WAITC = 2;

    logic        clk;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [3:0]  req_be;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic [1:0]  dbg_state;

    int total = 0;
    int bad   = 0;

    logic [31:0] model_mem [DEPTH];
    logic [31:0] exp_q[$];
    logic        exp_err_q[$];

    dmem_responder #(
        .DEPTH_WORDS (DEPTH),
        .WAIT_CYCLES (WAITC)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_write (req_write),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .req_be    (req_be),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_rdata (rsp_rdata),
        .rsp_err   (rsp_err),
        .dbg_state (dbg_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // model: compute expected response and update reference memory
    task automatic model_push(input logic wr, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [3:0] be);
        logic err;
        int   idx;
        err = (addr[1:0] != 2'b00) || (addr[31:2] >= 30'(DEPTH));
        idx = int'(addr[9:2]);
        if (err) begin
            exp_q.push_back(32'h0);
            exp_err_q.push_back(1'b1);
        end else if (wr) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) model_mem[idx][8*b +: 8] = wdata[8*b +: 8];
            exp_q.push_back(32'h0);
            exp_err_q.push_back(1'b0);
        end else begin
            exp_q.push_back(model_mem[idx]);
            exp_err_q.push_back(1'b0);
        end
    endtask

    // driver
    task automatic issue_req(input logic wr, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [3:0] be);
        int n;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_be    = be;
        n = 0;
        while (!req_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            total++; bad++;
            $display("FAIL accept_timeout: req_ready=%b required=1", req_ready);
        end
        @(posedge clk);
        #1;
        // scramble inputs to prove fields were latched at acceptance
        req_valid = 1'b0;
        req_write = 1'($urandom_range(0, 1));
        req_addr  = $urandom;
        req_wdata = $urandom;
        req_be    = 4'($urandom_range(0, 15));
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL accepted: req_ready=%b required=0", req_ready);
        end
        model_push(wr, addr, wdata, be);
    endtask

    // monitor + scoreboard compare; call right after the acceptance edge
    task automatic wait_rsp();
        int n;
        logic [31:0] e_data;
        logic        e_err;
        n = 0;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!rsp_valid && n < 40);
        total++;
        if (n !== WAITC + 1) begin
            bad++;
            $display("FAIL latency: edges=%0d required=%0d", n, WAITC + 1);
        end
        total++;
        if (req_ready !== 1'b0) begin
            bad++;
            $display("FAIL ready_vs_valid: req_ready=%b required=0 while rsp_valid", req_ready);
        end
        if (exp_q.size() == 0) begin
            total++; bad++;
            $display("FAIL scoreboard_empty: got rsp with no expectation");
        end else begin
            e_data = exp_q.pop_front();
            e_err  = exp_err_q.pop_front();
            total++;
            if (rsp_rdata !== e_data) begin
                bad++;
                $display("FAIL rsp_rdata: got=%h required=%h", rsp_rdata, e_data);
            end
            total++;
            if (rsp_err !== e_err) begin
                bad++;
                $display("FAIL rsp_err: got=%b required=%b", rsp_err, e_err);
            end
        end
    endtask

    task automatic complete_rsp();
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL complete: rsp_valid=%b req_ready=%b required 0/1", rsp_valid, req_ready);
        end
    endtask

    task automatic do_req(input logic wr, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be);
        issue_req(wr, addr, wdata, be);
        wait_rsp();
        complete_rsp();
    endtask

    task automatic test_reset();
        reset_n   = 1'b0;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_be    = '0;
        rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: rdy=%b vld=%b rdata=%h err=%b st=%0d required 1/0/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state);
        end
    endtask

    task automatic test_store_load();
        do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'b1111);
        do_req(1'b0, 32'h10, 32'h0, 4'b0000);
    endtask

    task automatic test_byte_enables();
        do_req(1'b1, 32'h10, 32'h11223344, 4'b0101);
        do_req(1'b0, 32'h10, 32'h0, 4'b1111);
        total++;
        if (model_mem[4] !== 32'hDE22BE44) begin
            bad++;
            $display("FAIL be_model: got=%h required=DE22BE44", model_mem[4]);
        end
        do_req(1'b1, 32'h10, 32'hFFFFFFFF, 4'b0000);
        do_req(1'b0, 32'h10, 32'h0, 4'b0000);
    endtask

    task automatic test_errors();
        do_req(1'b0, 32'h13, 32'h0, 4'b1111);
        do_req(1'b1, 32'h3FC, 32'hA5A55A5A, 4'b1111);
        do_req(1'b1, 32'h400, 32'h12345678, 4'b1111);
        do_req(1'b0, 32'h3FC, 32'h0, 4'b0000);
        do_req(1'b1, 32'h22, 32'h87654321, 4'b1111);
    endtask

    task automatic test_backpressure();
        issue_req(1'b0, 32'h10, 32'h0, 4'b0000);
        wait_rsp();
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h10;
        req_be    = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            total++;
            if (rsp_valid !== 1'b1 || rsp_rdata !== model_mem[4] || req_ready !== 1'b0) begin
                bad++;
                $display("FAIL bp_hold%0d: vld=%b rdata=%h rdy=%b required 1/%h/0",
                         i, rsp_valid, rsp_rdata, req_ready, model_mem[4]);
            end
        end
        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready = 1'b0;
        total++;
        if (rsp_valid !== 1'b0 || req_ready !== 1'b1) begin
            bad++;
            $display("FAIL bp_release: vld=%b rdy=%b required 0/1", rsp_valid, req_ready);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        total++;
        if (dbg_state !== ST_WAIT) begin
            bad++;
            $display("FAIL bp_pending_accept: state=%0d required=%0d", dbg_state, ST_WAIT);
        end
        model_push(1'b0, 32'h10, 32'h0, 4'b0000);
        wait_rsp();
        complete_rsp();
    endtask

    task automatic test_reset_mid_store();
        do_req(1'b1, 32'h20, 32'h0, 4'b1111);
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_addr  = 32'h20;
        req_wdata = 32'hCAFEF00D;
        req_be    = 4'b1111;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        reset_n   = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1 || rsp_valid !== 1'b0 || rsp_rdata !== 32'h0 ||
            rsp_err !== 1'b0 || dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL mid_reset: rdy=%b vld=%b rdata=%h err=%b st=%0d required 1/0/0/0/0",
                     req_ready, rsp_valid, rsp_rdata, rsp_err, dbg_state);
        end
        repeat (4) @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        do_req(1'b0, 32'h20, 32'h0, 4'b0000);
    endtask

    task automatic test_random();
        for (int i = 0; i < 8; i++)
            do_req(1'b1, 32'(i * 4), $urandom, 4'b1111);
        for (int i = 0; i < 24; i++) begin
            logic [31:0] a;
            a = 32'($urandom_range(0, 7) * 4);
            if ($urandom_range(0, 5) == 0) a[1:0] = 2'($urandom_range(1, 3));
            do_req(1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)));
        end
    endtask

    initial begin
        test_reset();
        test_store_load();
        test_byte_enables();
        test_errors();
        test_backpressure();
        test_reset_mid_store();
        test_random();
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL leftover: pending=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
